// File: rtl/vc_demux_router_pkg.sv
// Shared vc definitions for the demux router: select width, port limit, drop counter.
// Scrub option (in the slot): VC_DEMUX_ROUTER_SCRUB_EN.
`ifndef VC_DEMUX_ROUTER_PKG_SV
`define VC_DEMUX_ROUTER_PKG_SV
package vc_demux_router_pkg;
  localparam int VC_SEL_W     = 3;
  localparam int VC_MAX_PORTS = 8;
  localparam int VC_DROP_W    = 8;
  localparam logic [VC_DROP_W-1:0] VC_DROP_MAX = '1;

  // A select is legal when it names an instantiated port.
  function automatic logic sel_in_range(input logic [VC_SEL_W-1:0] sel, input int nports);
    return ({1'b0, sel} < (VC_SEL_W+1)'(nports));
  endfunction
endpackage
`endif

// File: rtl/vc_demux_router_slot.sv
// One-entry output buffer: full flag plus data register with enq/deq.
// VC_DEMUX_ROUTER_SCRUB_EN: data clears to 0 on a dequeue with no refill.
module vc_demux_router_slot #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq,
  input  logic               deq,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               full,
  output logic [p_nbits-1:0] data
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (enq) begin
      // enqueue wins over a same-cycle dequeue: slot stays full with new data
      full <= 1'b1;
      data <= enq_msg;
    end else if (deq) begin
      full <= 1'b0;
`ifdef VC_DEMUX_ROUTER_SCRUB_EN
      data <= '0;
`endif
    end
  end
endmodule

// File: rtl/vc_demux_router.sv
// Val/rdy demux: one input stream steered by in_sel to p_nports buffered outputs.
// Out-of-range selects are consumed and counted; scrub option VC_DEMUX_ROUTER_SCRUB_EN lives in the slot.
module vc_demux_router
  import vc_demux_router_pkg::*;
#(
  parameter int p_nbits  = 32,
  parameter int p_nports = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [VC_SEL_W-1:0]        in_sel,
  input  logic [p_nbits-1:0]         in_msg,
  output logic [p_nports-1:0]        out_val,
  input  logic [p_nports-1:0]        out_rdy,
  output logic [p_nports*p_nbits-1:0] out_msg,
  output logic [VC_DROP_W-1:0]       drop_count
);
  logic                              sel_ok;
  logic                              accept;
  logic [VC_MAX_PORTS-1:0]           port_rdy;
  logic [p_nports-1:0]               full;
  logic [p_nports-1:0]               enq;
  logic [p_nports-1:0][p_nbits-1:0]  data;

  assign sel_ok = sel_in_range(in_sel, p_nports);

  // Pad per-port readiness to the full select range so in_sel always indexes in bounds.
  always_comb begin
    port_rdy = '0;
    port_rdy[p_nports-1:0] = ~full | out_rdy;
  end

  assign in_rdy = sel_ok ? port_rdy[in_sel] : 1'b1;
  assign accept = in_val && in_rdy;

  for (genvar i = 0; i < p_nports; i++) begin : g_slot
    assign enq[i] = accept && sel_ok && (in_sel == VC_SEL_W'(i));
    vc_demux_router_slot #(.p_nbits(p_nbits)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .enq     (enq[i]),
      .deq     (full[i] && out_rdy[i]),
      .enq_msg (in_msg),
      .full    (full[i]),
      .data    (data[i])
    );
  end

  assign out_val = full;
  assign out_msg = data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (accept && !sel_ok && drop_count != VC_DROP_MAX)
      drop_count <= drop_count + 1'b1;
  end
endmodule

// File: tb/tb_vc_demux_router.sv
// Self-checking bench for vc_demux_router (p_nports=4): directed scenarios plus a
// randomized run against a per-port one-deep queue model.
module tb_vc_demux_router;
  localparam int N = 32;
  localparam int P = 4;
`ifdef VC_DEMUX_ROUTER_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_val;
  logic           in_rdy;
  logic [2:0]     in_sel;
  logic [N-1:0]   in_msg;
  logic [P-1:0]   out_val;
  logic [P-1:0]   out_rdy;
  logic [P*N-1:0] out_msg;
  logic [7:0]     drop_count;

  int errors = 0;
  int checks = 0;

  vc_demux_router #(.p_nbits(N), .p_nports(P)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel),
    .in_msg(in_msg), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_val !== 4'b0000) begin errors++; $display("FAIL reset_out_val got=%b exp=0000", out_val); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if (out_msg !== '0) begin errors++; $display("FAIL reset_out_msg got=%h exp=0", out_msg); end
    in_sel = 3'd0; #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_rdy = 4'hF; in_val = 1'b1; in_sel = 3'd2; in_msg = 32'hA5A5_0001; #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL single_in_rdy got=%b exp=1", in_rdy); end
    tick();
    in_val = 1'b0;
    checks++; if (out_val !== 4'b0100) begin errors++; $display("FAIL single_out_val got=%b exp=0100", out_val); end
    checks++; if (out_msg[2*N +: N] !== 32'hA5A5_0001) begin errors++; $display("FAIL single_slice got=%h exp=a5a50001", out_msg[2*N +: N]); end
    tick();
    checks++; if (out_val !== 4'b0000) begin errors++; $display("FAIL single_clear got=%b exp=0000", out_val); end
  endtask

  task automatic test_backpressure();
    out_rdy = 4'b1101; in_val = 1'b1; in_sel = 3'd1; in_msg = 32'h1111_0001; #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_first_rdy got=%b exp=1", in_rdy); end
    tick();
    in_msg = 32'h1111_0002; #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_second_rdy got=%b exp=0", in_rdy); end
    checks++; if (out_val !== 4'b0010) begin errors++; $display("FAIL bp_out_val got=%b exp=0010", out_val); end
    in_sel = 3'd3; #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_other_port_rdy got=%b exp=1", in_rdy); end
    in_sel = 3'd1; in_val = 1'b0; #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_no_val got=%b exp=0", in_rdy); end
    in_val = 1'b1;
    tick();
    checks++; if (out_msg[N +: N] !== 32'h1111_0001) begin errors++; $display("FAIL bp_stable got=%h exp=11110001", out_msg[N +: N]); end
    out_rdy = 4'hF; #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", in_rdy); end
    tick();
    in_val = 1'b0;
    checks++; if (out_val !== 4'b0010 || out_msg[N +: N] !== 32'h1111_0002) begin
      errors++; $display("FAIL bp_second_delivered got=%b/%h exp=0010/11110002", out_val, out_msg[N +: N]); end
    tick();
    checks++; if (out_val !== 4'b0000) begin errors++; $display("FAIL bp_drain got=%b exp=0000", out_val); end
  endtask

  task automatic test_back_to_back();
    out_rdy = 4'hF;
    for (int i = 0; i < P; i++) begin
      in_val = 1'b1; in_sel = 3'(i); in_msg = 32'hB000_0000 + i; #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy port=%0d got=%b exp=1", i, in_rdy); end
      tick();
      checks++; if (out_val !== 4'(1 << i) || out_msg[i*N +: N] !== 32'hB000_0000 + i) begin
        errors++; $display("FAIL b2b_out port=%0d got=%b/%h exp=%b/%h", i, out_val, out_msg[i*N +: N], 4'(1 << i), 32'hB000_0000 + i); end
    end
    in_val = 1'b0;
    tick();
    checks++; if (out_val !== 4'b0000) begin errors++; $display("FAIL b2b_drain got=%b exp=0000", out_val); end
  endtask

  task automatic test_drop();
    int rdy_bad = 0;
    int val_bad = 0;
    out_rdy = 4'hF; in_val = 1'b1; in_sel = 3'd5;
    for (int i = 0; i < 300; i++) begin
      in_msg = $urandom; #1;
      if (in_rdy !== 1'b1) rdy_bad++;
      tick();
      if (out_val !== 4'b0000) val_bad++;
    end
    in_val = 1'b0;
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL drop_in_rdy low_cycles=%0d exp=0", rdy_bad); end
    checks++; if (val_bad != 0) begin errors++; $display("FAIL drop_out_val bad_cycles=%0d exp=0", val_bad); end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d exp=255", drop_count); end
  endtask

  task automatic test_scrub();
    out_rdy = 4'hF; in_val = 1'b1; in_sel = 3'd3; in_msg = 32'hDEAD_BEEF;
    tick();
    in_val = 1'b0;
    checks++; if (out_val[3] !== 1'b1 || out_msg[3*N +: N] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL scrub_deliver got=%b/%h exp=1/deadbeef", out_val[3], out_msg[3*N +: N]); end
    tick();
    checks++; if (out_val[3] !== 1'b0) begin errors++; $display("FAIL scrub_val got=%b exp=0", out_val[3]); end
    checks++; if (out_msg[3*N +: N] !== (SCRUB ? 32'h0 : 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL scrub_slice got=%h exp=%h", out_msg[3*N +: N], SCRUB ? 32'h0 : 32'hDEAD_BEEF); end
  endtask

  // Reference: each port is a queue holding at most one message; out_msg shows the
  // held message, or the last one (zero under scrub) once it has been taken.
  task automatic test_random();
    logic [N-1:0] q [P][$];
    logic [N-1:0] shown [P];
    int           drops;
    logic         exp_rdy;
    logic [P-1:0] exp_val;
    logic [P*N-1:0] exp_msg;

    // start from a known state: reset while the outputs are busy
    out_rdy = 4'h0; in_val = 1'b1; in_sel = 3'd0; in_msg = 32'h5555_AAAA;
    tick();
    #2 reset = 1'b1; #1;
    checks++; if (out_val !== 4'b0000 || out_msg !== '0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL midreset_clear got=%b/%h/%0d exp=0/0/0", out_val, out_msg, drop_count); end
    in_val = 1'b0;
    tick();
    reset = 1'b0;
    for (int p = 0; p < P; p++) begin q[p].delete(); shown[p] = '0; end
    drops = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_sel  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      in_msg  = $urandom;
      out_rdy = 4'($urandom);
      #1;
      exp_rdy = (in_sel >= P) ? 1'b1 : (q[in_sel].size() == 0 || out_rdy[in_sel]);
      for (int p = 0; p < P; p++) begin
        exp_val[p] = (q[p].size() != 0);
        exp_msg[p*N +: N] = exp_val[p] ? q[p][0] : shown[p];
      end
      checks++; if (in_rdy !== exp_rdy) begin errors++; $display("FAIL rand_in_rdy cyc=%0d got=%b exp=%b", cyc, in_rdy, exp_rdy); end
      checks++; if (out_val !== exp_val) begin errors++; $display("FAIL rand_out_val cyc=%0d got=%b exp=%b", cyc, out_val, exp_val); end
      checks++; if (out_msg !== exp_msg) begin errors++; $display("FAIL rand_out_msg cyc=%0d got=%h exp=%h", cyc, out_msg, exp_msg); end
      checks++; if (drop_count !== 8'(drops)) begin errors++; $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", cyc, drop_count, drops); end
      // consumer pops happen first, then the accepted message lands
      for (int p = 0; p < P; p++)
        if (q[p].size() != 0 && out_rdy[p]) begin
          shown[p] = SCRUB ? '0 : q[p][0];
          void'(q[p].pop_front());
        end
      if (in_val && exp_rdy) begin
        if (in_sel >= P) drops = (drops < 255) ? drops + 1 : 255;
        else begin q[in_sel].push_back(in_msg); shown[in_sel] = in_msg; end
      end
      tick();
    end
    in_val = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_sel = 3'd0; in_msg = '0; out_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_scrub();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
